regs_wb_arbiter: RTL

- Shares the single write port of the 32x32 register file (r0 reads as zero, two read ports) between two writeback requesters: port A (ALU) and port B (load unit).
- Round-robin arbitration, a one-entry holding register per requester, and a registered write-port drive.
- A 32-entry busy scoreboard: destinations are marked busy at issue and released when their write reaches the register file, so the issue stage can stall on hazards.

---
 rtl/regs_wb_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/regs_wb_arbiter.sv
// rtl/regs_wb_arbiter.sv - round-robin writeback arbiter for the register-file write port with busy scoreboard
//
// Two writeback requesters (A = ALU, B = load unit) each feed a one-entry
// holding register. A round-robin arbiter moves one held entry per cycle into
// a registered register-file write port. A busy scoreboard marks destinations
// at issue and releases them when their write reaches the register file.
//
// Ports:
//   m_clock, p_reset          clock, asynchronous active-high reset
//   a_valid/a_ready/a_addr/a_data   requester A handshake and payload
//   b_valid/b_ready/b_addr/b_data   requester B handshake and payload
//   rf_write/rf_in_addr/rf_in       registered register-file write port
//   iss_valid/iss_addr              issuing instruction destination (marks busy)
//   chk_addr1/2, chk_busy1/2        combinational hazard lookups
//   busy_vec                        full scoreboard, bit 0 always 0
//   flush                           synchronous discard of pending writebacks and busy bits
module regs_wb_arbiter #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic             m_clock,
   input  logic             p_reset,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [AW-1:0]    a_addr,
   input  logic [DW-1:0]    a_data,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [AW-1:0]    b_addr,
   input  logic [DW-1:0]    b_data,
   output logic             rf_write,
   output logic [AW-1:0]    rf_in_addr,
   output logic [DW-1:0]    rf_in,
   input  logic             iss_valid,
   input  logic [AW-1:0]    iss_addr,
   input  logic [AW-1:0]    chk_addr1,
   input  logic [AW-1:0]    chk_addr2,
   output logic             chk_busy1,
   output logic             chk_busy2,
   output logic [2**AW-1:0] busy_vec,
   input  logic             flush
);

   localparam int NR = 2**AW;

   typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_t;

   logic          hold_a_v, hold_b_v;
   logic [AW-1:0] hold_a_addr, hold_b_addr;
   logic [DW-1:0] hold_a_data, hold_b_data;
   port_t         last;
   logic [NR-1:0] busy, busy_next;

   logic          grant_a, grant_b, acc_a, acc_b;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_data;

   always_comb begin
      // On a conflict the port that did not win last time is served.
      grant_a  = hold_a_v & (~hold_b_v | (last == PORT_B));
      grant_b  = hold_b_v & (~hold_a_v | (last == PORT_A));
      // A holding register being drained this cycle can be refilled at the same edge.
      a_ready  = ~p_reset & ~flush & (~hold_a_v | grant_a);
      b_ready  = ~p_reset & ~flush & (~hold_b_v | grant_b);
      acc_a    = a_valid & a_ready;
      acc_b    = b_valid & b_ready;
      win_addr = grant_a ? hold_a_addr : hold_b_addr;
      win_data = grant_a ? hold_a_data : hold_b_data;
   end

   always_comb begin
      busy_next = busy;
      if (rf_write)
         busy_next[rf_in_addr] = 1'b0;
      // Applied after the clear so a same-edge issue keeps the register busy.
      if (iss_valid && (iss_addr != '0))
         busy_next[iss_addr] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge m_clock or posedge p_reset) begin
      if (p_reset) begin
         hold_a_v    <= 1'b0;
         hold_b_v    <= 1'b0;
         hold_a_addr <= '0;
         hold_b_addr <= '0;
         hold_a_data <= '0;
         hold_b_data <= '0;
         last        <= PORT_B;
         rf_write    <= 1'b0;
         rf_in_addr  <= '0;
         rf_in       <= '0;
         busy        <= '0;
      end else if (flush) begin
         hold_a_v <= 1'b0;
         hold_b_v <= 1'b0;
         rf_write <= 1'b0;
         busy     <= '0;
      end else begin
         if (acc_a) begin
            hold_a_v    <= 1'b1;
            hold_a_addr <= a_addr;
            hold_a_data <= a_data;
         end else if (grant_a) begin
            hold_a_v <= 1'b0;
         end

         if (acc_b) begin
            hold_b_v    <= 1'b1;
            hold_b_addr <= b_addr;
            hold_b_data <= b_data;
         end else if (grant_b) begin
            hold_b_v <= 1'b0;
         end

         rf_write <= 1'b0;
         if (grant_a | grant_b) begin
            last <= grant_a ? PORT_A : PORT_B;
            // Writes to r0 are consumed silently; the port keeps its last values.
            if (win_addr != '0) begin
               rf_write   <= 1'b1;
               rf_in_addr <= win_addr;
               rf_in      <= win_data;
            end
         end

         busy <= busy_next;
      end
   end

   assign chk_busy1 = busy[chk_addr1];
   assign chk_busy2 = busy[chk_addr2];
   assign busy_vec  = busy;

endmodule
